// File: rtl/if_id_queue.sv
// if_id_queue: show-ahead circular fetch buffer between IF and ID; a redirect flushes it.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_id,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [CNT_W-1:0]  count
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic push, pop;
  always_comb begin
    if_ready = count_q != CNT_W'(DEPTH);
    id_valid = count_q != '0;
    id_pc    = id_valid ? pc_mem_q[rp_q] : '0;
    id_inst  = id_valid ? inst_mem_q[rp_q] : '0;
    push     = if_valid & if_ready & ~flush;
    pop      = id_valid & ~stall_id & ~flush;
    wp_d     = flush ? '0 : wp_q + PW'(push);
    rp_d     = flush ? '0 : rp_q + PW'(pop);
    count_d  = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    count    = count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end
  // Storage is never cleared; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wp_q]   <= if_pc;
      inst_mem_q[wp_q] <= if_inst;
    end
  end
endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter ADDR_W, default 32, width of instruction address.
REQ-002 Parameter INST_W, default 32, width of instruction word.
REQ-003 Parameter DEPTH, default 4, number of buffered fetch entries; power of two, >= 2.
REQ-004 Parameter CNT_W, default 3, width of occupancy count; SHALL equal clog2(DEPTH+1).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 flush  input  1  branch/jump redirect from EX; discards all buffered entries.
REQ-008 stall_id  input  1  ID stage cannot accept an entry this cycle.
REQ-009 if_valid  input  1  IF presents a fetched instruction.
REQ-010 if_pc  input  ADDR_W  address of fetched instruction.
REQ-011 if_inst  input  INST_W  fetched instruction word.
REQ-012 if_ready  output  1  queue can accept a push this cycle.
REQ-013 id_valid  output  1  head entry valid for ID.
REQ-014 id_pc  output  ADDR_W  head entry address.
REQ-015 id_inst  output  INST_W  head entry instruction.
REQ-016 count  output  CNT_W  current occupancy, 0..DEPTH.

Function
REQ-017 The block SHALL be a circular FIFO: DEPTH entries, write pointer wp, read pointer rp, occupancy count; pointers log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-018 if_ready SHALL be combinational: 1 iff count < DEPTH; no push into a full queue, even with a same-cycle pop.
REQ-019 push = if_valid & if_ready & ~flush; on push, entry[wp] <= {if_pc, if_inst}, wp <= wp+1.
REQ-020 pop = id_valid & ~stall_id & ~flush; on pop, rp <= rp+1.
REQ-021 count SHALL update as count + push - pop; simultaneous push and pop leaves count unchanged.
REQ-022 Show-ahead head: id_valid = (count != 0); id_pc/id_inst = entry[rp] when id_valid, else all-zero.
REQ-023 Latency: entry pushed at edge N is visible on id_* after edge N if queue was empty (one cycle push-to-head).
REQ-024 While stall_id = 1, id_* SHALL remain stable; pushes continue until full.
REQ-025 flush SHALL, at the next edge, set wp = rp = 0, count = 0; any same-cycle push or pop is discarded; id_valid = 0 in the following cycle.
REQ-026 Precedence: rst > flush > push/pop.
REQ-027 Order SHALL be strict FIFO; no entry duplicated or dropped except by flush/rst.
REQ-028 Entry storage contents need not be cleared by flush; only pointers and count.

Reset
REQ-029 While rst = 1 at an edge: wp = 0, rp = 0, count = 0; hence id_valid = 0, id_pc = 0, id_inst = 0, if_ready = 1.
REQ-030 Reset asserted mid-operation SHALL discard all entries, as flush, regardless of stall_id/if_valid.

Verification
REQ-031 Reset, then push pc 0x0000/inst 0x00000013 with stall_id=0 -> next cycle id_valid=1, id_pc=0x0000, id_inst=0x00000013; following cycle id_valid=0, count=0.
REQ-032 stall_id=1, push 4 entries pc 0x00,0x04,0x08,0x0C -> count=4, if_ready=0, id_pc=0x00 throughout; fifth if_valid ignored; release stall -> id_pc 0x00,0x04,0x08,0x0C on consecutive cycles.
REQ-033 count=2, push and pop same cycle -> count stays 2, head advances one entry.
REQ-034 count=3, flush=1 with if_valid=1 -> next cycle count=0, id_valid=0, if_ready=1; pushed pc absent afterwards.
REQ-035 Fill and drain 10 entries with random stall_id (DEPTH=4) -> output sequence equals input sequence, pointers wrap correctly.
REQ-036 rst=1 with count=4 and stall_id=1 -> next cycle count=0, id_pc=0, id_inst=0, if_ready=1.
